// File: rtl/phi_lut_arbiter.sv
// Round-robin arbiter sharing one phi LUT among N_REQ check-node lanes.
// One grant per cycle; the registered result carries the winning lane ID.

module phi_lut (
  input  logic [6:0] i_x,
  output logic [3:0] o_y
);
  // f(x) = log((1+e^-|x|)/(1-e^-|x|)), quantised to U2.2 and saturated at 15
  always_comb begin
    o_y = 4'd0;
    if (i_x == 7'd0)       o_y = 4'd15;
    else if (i_x == 7'd1)  o_y = 4'd8;
    else if (i_x == 7'd2)  o_y = 4'd6;
    else if (i_x == 7'd3)  o_y = 4'd4;
    else if (i_x == 7'd4)  o_y = 4'd3;
    else if (i_x <= 7'd6)  o_y = 4'd2;
    else if (i_x <= 7'd11) o_y = 4'd1;
    else                   o_y = 4'd0;
  end
endmodule

module phi_lut_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [7*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_y,
  output logic [ID_W-1:0]      out_id
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_g;
  logic            w_found;
  logic            w_can_accept;
  logic            w_accept;
  logic [6:0]      w_x;
  logic [3:0]      w_y;

  assign w_can_accept = !out_valid || out_ready;

  // Scan lanes starting at r_ptr, wrapping modulo N_REQ; first valid lane wins.
  always_comb begin : p_grant
    int v_idx;
    w_found = 1'b0;
    w_g     = '0;
    v_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_g     = ID_W'(v_idx);
      end
    end
  end

  // Ready is held low during reset so no handshake can complete in that cycle.
  assign w_accept = w_found && w_can_accept && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_g] = 1'b1;
  end

  assign w_x = req_x[7*int'(w_g) +: 7];

  phi_lut u_lut (
    .i_x (w_x),
    .o_y (w_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      out_valid <= 1'b0;
      out_y     <= 4'd0;
      out_id    <= '0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_y     <= w_y;
      out_id    <= w_g;
      r_ptr     <= (w_g == ID_W'(N_REQ-1)) ? '0 : w_g + ID_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phi_lut_arbiter.sv
// Scoreboard bench for phi_lut_arbiter: expected results are queued as lanes
// are driven and compared when the output port hands them off.

module tb_phi_lut_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [7*N_REQ-1:0] req_x = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         out_y;
  logic [ID_W-1:0]    out_id;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [3:0]      y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  phi_lut_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int y);
    exp_t e;
    e.id = ID_W'(id);
    e.y  = 4'(y);
    sb.push_back(e);
  endtask

  task automatic set_x(input int lane, input int x);
    req_x[7*lane +: 7] = 7'(x);
  endtask

  // Output-side scoreboard: pop on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("out_id", int'(out_id), int'(mon_e.id));
        chk("out_y",  int'(out_y),  int'(mon_e.y));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then idle
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_y",     int'(out_y),     0);
    chk("rst_id",    int'(out_id),    0);
    chk("rst_ready", int'(req_ready), 0);
    rst = 1'b0;
    tick();
    chk("idle_valid", int'(out_valid), 0);

    // Single lane
    out_ready = 1'b1;
    set_x(2, 1);
    req_valid = 4'b0100;
    push(2, 8);
    #1 chk("single_ready", int'(req_ready), 4'b0100);
    tick();
    req_valid = '0;
    chk("single_valid", int'(out_valid), 1);
    chk("single_y",     int'(out_y),     8);
    chk("single_id",    int'(out_id),    2);
    tick();
    chk("single_drain", int'(out_valid), 0);

    // Full contention from ptr=0, one result per cycle
    rst = 1'b1; tick(); rst = 1'b0;
    set_x(0, 0); set_x(1, 2); set_x(2, 4); set_x(3, 12);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: push(0, 15);
        1: push(1, 6);
        2: push(2, 3);
        default: push(3, 0);
      endcase
      #1 chk("rr_ready", int'(req_ready), 1 << (i % 4));
      tick();
      chk("rr_valid", int'(out_valid), 1);
    end
    req_valid = '0;
    tick();
    chk("rr_drain", int'(out_valid), 0);

    // Backpressure with lanes 0 and 1
    out_ready = 1'b0;
    set_x(0, 3); set_x(1, 7);
    req_valid = 4'b0011;
    push(0, 4); push(1, 1);
    #1 chk("bp_ready0", int'(req_ready), 4'b0001);
    tick();
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_ready", int'(req_ready), 0);
      chk("bp_stall_valid", int'(out_valid), 1);
      chk("bp_stall_y",     int'(out_y),     4);
      chk("bp_stall_id",    int'(out_id),    0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_ready1", int'(req_ready), 4'b0010);
    tick();
    req_valid = '0;
    chk("bp_y1",  int'(out_y),  1);
    chk("bp_id1", int'(out_id), 1);
    tick();

    // Pointer wrap and fairness
    set_x(3, 5);
    req_valid = 4'b1000;
    push(3, 2);
    tick();
    set_x(0, 6); set_x(3, 11);
    req_valid = 4'b1001;
    push(0, 2); push(3, 1);
    #1 chk("fair_ready0", int'(req_ready), 4'b0001);
    tick();
    req_valid = 4'b1000;
    #1 chk("fair_ready3", int'(req_ready), 4'b1000);
    tick();
    req_valid = '0;
    tick();
    chk("fair_drain", int'(out_valid), 0);

    // Reset mid-stall: held result is dropped, scan restarts at lane 0
    out_ready = 1'b0;
    set_x(1, 127);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    chk("ms_stall_valid", int'(out_valid), 1);
    chk("ms_stall_y",     int'(out_y),     0);
    chk("ms_stall_id",    int'(out_id),    1);
    rst = 1'b1;
    set_x(1, 9); set_x(2, 2);
    req_valid = 4'b0110;
    tick();
    rst = 1'b0;
    chk("ms_rst_valid", int'(out_valid), 0);
    chk("ms_rst_id",    int'(out_id),    0);
    out_ready = 1'b1;
    push(1, 1);
    #1 chk("ms_ready1", int'(req_ready), 4'b0010);
    tick();
    req_valid = 4'b0100;
    push(2, 6);
    #1 chk("ms_ready2", int'(req_ready), 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/phi_lut_arbiter.md
Name: phi_lut_arbiter

Overview:
Round-robin arbiter that shares one instance of the 7-bit-to-4-bit phi lookup module (f(x) = log((1+e^-|x|)/(1-e^-|x|))) among N_REQ check-node lanes.
Each lane presents a magnitude with a valid/ready handshake. The arbiter grants one lane per cycle, drives the LUT, and registers the 4-bit result with the lane ID on an output valid/ready port.
It sits between the check-node magnitude extractors and the check-node sum accumulators.

Parameters:
N_REQ, 4, number of requesting lanes (2..8)
ID_W, 2, width of lane ID; must equal ceil(log2(N_REQ)), minimum 1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-lane request valid
req_x  input  7*N_REQ  per-lane LUT input; lane i occupies bits [7*i+6 : 7*i]
req_ready  output  N_REQ  per-lane accept; a handshake occurs when req_valid[i] and req_ready[i] are both high
out_valid  output  1  result register holds valid data
out_ready  input  1  downstream accepts the result
out_y  output  4  LUT result in U2.2 format (LSB = 0.25)
out_id  output  ID_W  index of the lane whose request produced out_y

Behaviour:
- Reset (rst=1 at a clock edge):
  - ptr=0, out_valid=0, out_y=0, out_id=0.
  - Any held result is discarded. No accept occurs in a reset cycle.
- Capacity: can_accept = !out_valid | out_ready (combinational).
- Grant (combinational):
  - Scan lanes ptr, ptr+1, ..., wrapping modulo N_REQ. The first lane with req_valid=1 is the winner g.
  - req_ready[g] = can_accept; all other req_ready bits = 0.
  - If no lane is valid, req_ready = 0.
  - req_ready must not depend on out_y or out_id.
- Accept (at a clock edge, when can_accept and any req_valid):
  - out_y <= LUT(req_x[g]); out_id <= g; out_valid <= 1; ptr <= (g+1) mod N_REQ.
- Drain: when out_valid & out_ready and nothing is accepted, out_valid <= 0. out_y and out_id hold their last values.
- Stall: when out_valid & !out_ready, out_valid, out_y, out_id and ptr hold, and all req_ready bits are 0.
- Latency and throughput:
  - Exactly 1 cycle from accept to out_valid.
  - Sustained throughput is 1 result per cycle while out_ready=1 (simultaneous drain and accept in the same cycle).
- ptr advances only on an accept, never on idle cycles.
  - Fairness bound: a continuously valid lane is granted within N_REQ accepts.
- Lane contract: a lane keeps req_valid and req_x stable until its handshake. The arbiter does not check this.
- LUT contents (as implemented by the shared LUT module):
  - x=0 -> 15; 1 -> 8; 2 -> 6; 3 -> 4; 4 -> 3.
  - 5,6 -> 2; 7..11 -> 1; 12..127 -> 0.
- Wrap: with N_REQ not a power of two, ptr wraps from N_REQ-1 to 0. ID values >= N_REQ never appear.
- Reset mid-stall: a pending result is dropped. After rst deasserts, the arbitration scan starts at lane 0.

Test Plan:
- Reset then idle: rst held 3 cycles, no requests -> out_valid=0, out_y=0, out_id=0, req_ready=0000.
- Single lane: lane 2 valid with x=1, out_ready=1 -> req_ready=0100 in the request cycle; next cycle out_valid=1, out_y=8, out_id=2.
- Full contention, no backpressure: all 4 lanes valid continuously with x=0,2,4,12, out_ready=1 -> out_id sequence 0,1,2,3,0,... and out_y sequence 15,6,3,0 repeating, one result per cycle.
- Backpressure: lanes 0 and 1 valid (x=3, x=7), out_ready=0 for 3 cycles after the first accept -> out_valid=1, out_y=4, out_id=0 held, req_ready=00. Raise out_ready -> lane 1 is accepted in the same cycle as the drain; next cycle out_y=1, out_id=1.
- Pointer fairness: lane 3 accepted, then lanes 0 and 3 both valid -> lane 0 is granted first (ptr=0 after wrap), then lane 3.
- Reset mid-stall: out_valid=1 with out_ready=0, pulse rst for 1 cycle -> out_valid=0. The first grant after reset goes to the lowest valid lane.
